// File: rtl/test_counter_bank.sv
// Counter bank: CHANNELS up/down/load counters with a shared prescaler, muxed readout and sticky wrap flags.
// Build option: define TEST_COUNTER_BANK_SATURATE_EN for saturating counters (default is modulo wrap).

module test_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            div,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(CHANNELS)-1:0] cmd_ch,
  input  logic [WIDTH-1:0]            cmd_data,
  input  logic [$clog2(CHANNELS)-1:0] sel_ch,
  output logic [WIDTH-1:0]            count_out,
  output logic [CHANNELS-1:0]         wrap_flags,
  output logic                        tick
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    OP_STOP = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_APPLY
  } state_e;

  // Reset release synchroniser: the core stays in reset for two edges after rst falls.
  logic [1:0] rst_sync;
  logic       core_rst;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign core_rst = rst_sync[1];

  // Prescaler; a div lowered below the current count makes it wrap through its maximum.
  logic [DIV_W-1:0] pre_q;
  logic             pre_hit;

  assign pre_hit = (pre_q == div);
  assign tick    = pre_hit & ~core_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pre_q <= '0;
    else if (core_rst) pre_q <= '0;
    else if (pre_hit) pre_q <= '0;
    else              pre_q <= pre_q + DIV_W'(1);
  end

  // Command FSM
  state_e            state_q, state_d;
  op_e               op_q;
  logic [CH_W-1:0]   ch_q;
  logic [WIDTH-1:0]  data_q;
  logic              cmd_fire;
  logic              apply;

  assign cmd_ready = (state_q == S_IDLE) & ~core_rst;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign apply     = (state_q == S_APPLY);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_STOP;
      ch_q    <= '0;
      data_q  <= '0;
    end else if (core_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_STOP;
      ch_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        op_q   <= op_e'(cmd_op);
        ch_q   <= cmd_ch;
        data_q <= cmd_data;
      end
    end
  end

  // Counter array: the targeted channel takes the command and skips any coincident tick.
  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    cnt_d  [CHANNELS];
  op_e                 mode_q [CHANNELS];
  op_e                 mode_d [CHANNELS];
  logic [CHANNELS-1:0] wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wrap_d = wrap_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (apply && (ch_q == CH_W'(i))) begin
        if (op_q == OP_LOAD) begin
          cnt_d[i]  = data_q;
          wrap_d[i] = 1'b0;
        end else begin
          mode_d[i] = op_q;
        end
      end else if (tick) begin
        case (mode_q[i])
          OP_UP: begin
`ifdef TEST_COUNTER_BANK_SATURATE_EN
            if (cnt_q[i] == CNT_MAX) wrap_d[i] = 1'b1;
            else                     cnt_d[i]  = cnt_q[i] + WIDTH'(1);
`else
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
            if (cnt_q[i] == CNT_MAX) wrap_d[i] = 1'b1;
`endif
          end
          OP_DOWN: begin
`ifdef TEST_COUNTER_BANK_SATURATE_EN
            if (cnt_q[i] == '0) wrap_d[i] = 1'b1;
            else                cnt_d[i]  = cnt_q[i] - WIDTH'(1);
`else
            cnt_d[i] = cnt_q[i] - WIDTH'(1);
            if (cnt_q[i] == '0) wrap_d[i] = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the counter array is plain flops, not RAM, so it is reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        mode_q[i] <= OP_STOP;
      end
      wrap_q <= '0;
    end else if (core_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        mode_q[i] <= OP_STOP;
      end
      wrap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

  assign count_out  = cnt_q[sel_ch];
  assign wrap_flags = wrap_q;

endmodule

// File: doc/test_counter_bank.md
# test_counter_bank

Parametrised multi-channel counter bank for tile bring-up and I/O test. It holds CHANNELS independent WIDTH-bit counters behind a shared programmable prescaler, and each counter can be stopped, run up, run down or loaded through a valid/ready command port. Any one counter can be read out on a muxed output, and each channel has a sticky wrap flag. It sits between the tile pin wrapper and the pads as the standard self-test payload.

## Interface
Parameters:
- WIDTH, 8, bits per counter (2..16)
- CHANNELS, 4, number of counters (power of two, 2..8)
- DIV_W, 4, width of prescaler divisor

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- div  in  DIV_W  prescaler divisor; tick every div+1 cycles (quasi-static)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept
- cmd_op  in  2  0=STOP, 1=RUN_UP, 2=RUN_DOWN, 3=LOAD
- cmd_ch  in  log2(CHANNELS)  target channel
- cmd_data  in  WIDTH  load value (LOAD only)
- sel_ch  in  log2(CHANNELS)  readout select
- count_out  out  WIDTH  counter[sel_ch]
- wrap_flags  out  CHANNELS  sticky per-channel wrap flags
- tick  out  1  prescaler tick, one cycle wide

## Operation
- Reset release: rst clears all state immediately. Release is synchronised through 2 flops, so the core stays in reset for 2 rising edges after rst falls.
- Reset values: all counters 0, all modes STOP, wrap_flags 0, prescaler 0, tick 0, cmd_ready 0. cmd_ready stays 0 until the sync window ends.
- Prescaler:
  - DIV_W counter. When it equals div, tick=1 for that cycle and the counter returns to 0; otherwise it increments.
  - div=0 gives a tick every cycle.
  - If div changes below the current prescaler count, the counter wraps through its maximum before it can match.
- Counter behaviour on tick:
  - RUN_UP adds 1, modulo 2^WIDTH.
  - RUN_DOWN subtracts 1, modulo 2^WIDTH.
  - STOP holds.
- Wrap flag: set on the transition max->0 (up) or 0->max (down). Cleared only by LOAD to that channel or by reset.
- Command FSM, two states:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready registers op/ch/data and moves to APPLY.
  - APPLY: cmd_ready=0. The registered command is written at the end of the cycle, then the FSM returns to IDLE.
  - Sustained throughput is one command per 2 cycles.
- Command effects:
  - STOP, RUN_UP, RUN_DOWN set the channel mode only.
  - LOAD writes cmd_data to the counter, clears its wrap flag and keeps its mode.
- Collision: if tick occurs in the APPLY cycle, the targeted channel takes the command and ignores the tick. All other channels advance normally.
- cmd_valid must hold its payload until accepted. Inputs sampled while cmd_ready=0 are ignored.
- rst asserted during APPLY discards the pending command.

## Timing
- count_out and wrap_flags are combinational views of registers. sel_ch change is visible in the same cycle.
- Command accepted at edge N: mode or value changes at edge N+1 and is visible after it.
- First tick after reset release: div+1 cycles after the first non-reset edge.
- Counter update latency: the register changes on the edge that ends the tick cycle.

## Configuration
- TEST_COUNTER_BANK_SATURATE_EN
  - Defined: counters saturate; RUN_UP holds at 2^WIDTH-1 and RUN_DOWN holds at 0. The wrap flag sets on the first tick attempted while at the limit.
  - Undefined: modulo wrap as described above.
  - The command interface and all timing are identical in both builds.

## Test plan
- Reset: rst pulse mid-count -> counters 0, wrap_flags 0. cmd_ready 0 for exactly 2 edges after release, then 1.
- Prescale: div=3, LOAD ch0=0x00, RUN_UP ch0 -> count_out(sel 0) increments once per 4 cycles and tick period is 4.
- Wrap: WIDTH=8, LOAD ch1=0xFE, RUN_UP, div=0 -> 0xFF, 0x00, wrap_flags[1]=1. A following LOAD clears it.
- Down/saturate: LOAD ch2=0x01, RUN_DOWN, div=0 -> 0x00, then 0xFF with flag (default build), or 0x00 held with flag (SATURATE build).
- Collision: div=0, ch3 running up at 0x10, LOAD ch3=0x80 -> ch3 reads 0x80 after APPLY, not 0x81. The other channels still advance that cycle.
- Handshake: cmd_valid held high with 4 back-to-back commands -> accepted on every other cycle, and no command is lost or duplicated.
